// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - CIC decimator sequencer: clock enables, flush, one-entry output register
// Replaces the divided comb clock with strobes on clk; the ratio is programmable while IDLE.
module cic_decim_ctrl #(
  parameter int STAGES   = 2,
  parameter int RATE_W   = 4,
  parameter int DATA_W   = 5,
  parameter int RATE_RST = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cfg_we,
  input  logic [RATE_W-1:0] cfg_rate,
  input  logic              ovr_clr,
  output logic              integ_en,
  output logic              comb_stb,
  input  logic [DATA_W-1:0] comb_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun,
  output logic [1:0]        state,
  output logic [7:0]        sample_cnt
);

  // flush_cnt only has to reach STAGES-1; the final strobe moves the FSM on
  localparam int FC_W = (STAGES < 2) ? 1 : $clog2(STAGES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    RUN   = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [RATE_W-1:0] phase_q, phase_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [FC_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              overrun_q, overrun_d;
  logic [7:0]        sample_cnt_q, sample_cnt_d;

  logic active, stb, capture, xfer;

  assign active  = (state_q != IDLE);
  assign stb     = active && (phase_q == rate_q);
  assign capture = stb && ((state_q == RUN) || (state_q == STOP));
  assign xfer    = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    rate_d      = rate_q;
    flush_cnt_d = flush_cnt_q;
    if (active) begin
      phase_d = stb ? '0 : phase_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          rate_d = cfg_rate;
        end
        if (run) begin
          state_d     = FLUSH;
          phase_d     = '0;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        if (!run) begin
          state_d     = IDLE;
          phase_d     = '0;
          flush_cnt_d = '0;
        end else if (stb) begin
          if (flush_cnt_q == FC_W'(STAGES - 1)) begin
            state_d     = RUN;
            flush_cnt_d = '0;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (!run) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // the strobe ending the period also wraps phase back to 0
        if (run) begin
          state_d = RUN;
        end else if (stb) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    overrun_d    = overrun_q;
    sample_cnt_d = sample_cnt_q;
    if (xfer) begin
      sample_cnt_d = sample_cnt_q + 8'd1;
      out_valid_d  = 1'b0;
    end
    if (capture) begin
      out_data_d  = comb_data;
      out_valid_d = 1'b1;
    end
    if (ovr_clr || ((state_q == IDLE) && cfg_we)) begin
      overrun_d = 1'b0;
    end
    if (capture && out_valid_q && !out_ready) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      phase_q      <= '0;
      rate_q       <= RATE_W'(RATE_RST);
      flush_cnt_q  <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      sample_cnt_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      rate_q       <= rate_d;
      flush_cnt_q  <= flush_cnt_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign integ_en   = active;
  assign comb_stb   = stb;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign overrun    = overrun_q;
  assign state      = state_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - directed-vector bench for cic_decim_ctrl
module tb_cic_decim_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       cfg_we;
  logic [3:0] cfg_rate;
  logic       ovr_clr;
  logic       integ_en;
  logic       comb_stb;
  logic [4:0] comb_data;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic [1:0] state;
  logic [7:0] sample_cnt;

  int n_vec = 0;
  int n_err = 0;

  cic_decim_ctrl #(.STAGES(2), .RATE_W(4), .DATA_W(5), .RATE_RST(3)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .cfg_we(cfg_we), .cfg_rate(cfg_rate),
    .ovr_clr(ovr_clr), .integ_en(integ_en), .comb_stb(comb_stb), .comb_data(comb_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .overrun(overrun),
    .state(state), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  task automatic drain(input logic [7:0] exp_cnt);
    int n;
    n = 0;
    run = 1'b0;
    out_ready = 1'b1;
    while (state !== 2'd0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    n_vec++;
    if (state !== 2'd0) begin n_err++; $display("FAIL drain_idle got %0d exp 0", state); end
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid got %b exp 0", out_valid); end
    n_vec++;
    if (sample_cnt !== exp_cnt) begin n_err++; $display("FAIL drain_cnt got %0d exp %0d", sample_cnt, exp_cnt); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; cfg_we = 1'b0; cfg_rate = 4'd0; ovr_clr = 1'b0;
    comb_data = 5'd0; out_ready = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({state, integ_en, comb_stb, out_valid, out_data, overrun, sample_cnt} !== 19'd0) begin
      n_err++;
      $display("FAIL reset_outputs got st=%0d ie=%b cs=%b ov=%b od=%0d or=%b cnt=%0d exp all 0",
               state, integ_en, comb_stb, out_valid, out_data, overrun, sample_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (state !== 2'd0 || integ_en !== 1'b0) begin n_err++; $display("FAIL reset_idle got st=%0d ie=%b exp 0 0", state, integ_en); end
  endtask

  task automatic test_first_sample();
    run = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n_vec++;
      if (comb_stb !== ((k % 4) == 3)) begin n_err++; $display("FAIL t1_stb k=%0d got %b exp %b", k, comb_stb, ((k % 4) == 3)); end
      n_vec++;
      if (state !== ((k < 8) ? 2'd1 : 2'd2)) begin n_err++; $display("FAIL t1_state k=%0d got %0d exp %0d", k, state, (k < 8) ? 1 : 2); end
      n_vec++;
      if (integ_en !== 1'b1) begin n_err++; $display("FAIL t1_integ k=%0d got %b exp 1", k, integ_en); end
      if (k == 11) begin
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_valid_early got %b exp 0", out_valid); end
      end
      if (k == 12) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 5'd12) begin n_err++; $display("FAIL t1_first got v=%b d=%0d exp v=1 d=12", out_valid, out_data); end
      end
      if (k == 13) begin
        n_vec++;
        if (sample_cnt !== 8'd1) begin n_err++; $display("FAIL t1_cnt got %0d exp 1", sample_cnt); end
      end
      comb_data = 5'(k + 1);
    end
    drain(8'd3);
  endtask

  task automatic test_rate_one();
    cfg_we = 1'b1; cfg_rate = 4'd0;
    @(negedge clk);
    cfg_we = 1'b0; run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (comb_stb !== 1'b1) begin n_err++; $display("FAIL t2_stb k=%0d got %b exp 1", k, comb_stb); end
      n_vec++;
      if (state !== ((k < 2) ? 2'd1 : 2'd2)) begin n_err++; $display("FAIL t2_state k=%0d got %0d exp %0d", k, state, (k < 2) ? 1 : 2); end
      if (k >= 3) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 5'(k + 6)) begin n_err++; $display("FAIL t2_out k=%0d got v=%b d=%0d exp v=1 d=%0d", k, out_valid, out_data, k + 6); end
      end
      if (k == 7) begin
        n_vec++;
        if (sample_cnt !== 8'd7) begin n_err++; $display("FAIL t2_cnt got %0d exp 7", sample_cnt); end
      end
      cfg_we = (k == 2);
      cfg_rate = 4'd5;
      comb_data = 5'(k + 7);
    end
    drain(8'd10);
  endtask

  task automatic test_overrun();
    cfg_we = 1'b1; cfg_rate = 4'd3;
    @(negedge clk);
    cfg_we = 1'b0; run = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (k == 12) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 5'd23) begin n_err++; $display("FAIL t3_first got v=%b d=%0d exp v=1 d=23", out_valid, out_data); end
      end
      if (k == 15) begin
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL t3_ovr_pre got %b exp 0", overrun); end
      end
      if (k == 16) begin
        n_vec++;
        if (overrun !== 1'b1 || out_data !== 5'd31) begin n_err++; $display("FAIL t3_ovr_set got o=%b d=%0d exp o=1 d=31", overrun, out_data); end
      end
      if (k == 20) begin
        n_vec++;
        if (overrun !== 1'b1 || out_data !== 5'd7) begin n_err++; $display("FAIL t3_set_prio got o=%b d=%0d exp o=1 d=7", overrun, out_data); end
      end
      if (k == 21) begin
        n_vec++;
        if (overrun !== 1'b0) begin n_err++; $display("FAIL t3_clr got %b exp 0", overrun); end
      end
      ovr_clr = (k == 19) || (k == 20);
      comb_data = 5'(k * 2 + 1);
    end
    drain(8'd12);
  endtask

  task automatic test_stop();
    run = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k == 14) begin
        n_vec++;
        if (state !== 2'd3) begin n_err++; $display("FAIL t4_stop got %0d exp 3", state); end
      end
      if (k == 15) begin
        n_vec++;
        if (comb_stb !== 1'b1 || state !== 2'd3) begin n_err++; $display("FAIL t4_last_stb got cs=%b st=%0d exp 1 3", comb_stb, state); end
      end
      if (k == 16) begin
        n_vec++;
        if (state !== 2'd0 || integ_en !== 1'b0 || comb_stb !== 1'b0) begin n_err++; $display("FAIL t4_idle got st=%0d ie=%b cs=%b exp 0 0 0", state, integ_en, comb_stb); end
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 5'd3) begin n_err++; $display("FAIL t4_capture got v=%b d=%0d exp v=1 d=3", out_valid, out_data); end
      end
      if (k == 19) begin
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL t4_hold got %b exp 1", out_valid); end
      end
      if (k == 20) begin
        n_vec++;
        if (out_valid !== 1'b0 || sample_cnt !== 8'd14 || overrun !== 1'b0) begin n_err++; $display("FAIL t4_consume got v=%b cnt=%0d o=%b exp 0 14 0", out_valid, sample_cnt, overrun); end
      end
      out_ready = (k == 12) || (k >= 19);
      if (k == 13) run = 1'b0;
      comb_data = 5'(k + 20);
    end
  endtask

  task automatic test_flush_abort();
    run = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        n_vec++;
        if (comb_stb !== 1'b1) begin n_err++; $display("FAIL t5_stb1 got %b exp 1", comb_stb); end
      end
      if (k == 5) begin
        n_vec++;
        if (state !== 2'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL t5_abort got st=%0d v=%b exp 0 0", state, out_valid); end
      end
      if (k == 4) run = 1'b0;
      if (k == 6) run = 1'b1;
    end
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (j == 3) begin
        n_vec++;
        if (comb_stb !== 1'b1) begin n_err++; $display("FAIL t5_restb got %b exp 1", comb_stb); end
      end
      if (j == 4 || j == 7) begin
        n_vec++;
        if (state !== 2'd1) begin n_err++; $display("FAIL t5_reflush j=%0d got %0d exp 1", j, state); end
      end
      if (j == 8) begin
        n_vec++;
        if (state !== 2'd2) begin n_err++; $display("FAIL t5_run got %0d exp 2", state); end
      end
    end
    drain(8'd15);
  endtask

  task automatic test_async_reset();
    cfg_we = 1'b1; cfg_rate = 4'd1;
    @(negedge clk);
    cfg_we = 1'b0; run = 1'b1; out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      comb_data = 5'(k + 9);
    end
    n_vec++;
    if (out_valid !== 1'b1 || state !== 2'd2) begin n_err++; $display("FAIL t6_pre got v=%b st=%0d exp 1 2", out_valid, state); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({state, integ_en, comb_stb, out_valid, out_data, overrun, sample_cnt} !== 19'd0) begin
      n_err++;
      $display("FAIL t6_async got st=%0d ie=%b cs=%b ov=%b od=%0d or=%b cnt=%0d exp all 0",
               state, integ_en, comb_stb, out_valid, out_data, overrun, sample_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (comb_stb !== (k == 3)) begin n_err++; $display("FAIL t6_rate k=%0d got %b exp %b", k, comb_stb, (k == 3)); end
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_rate_one();
    test_overrun();
    test_stop();
    test_flush_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
